packing_dispatch: RTL and testbench

PACKING_DISPATCH -- requirements
Module: packing_dispatch

---
 rtl/packing_dispatch_pkg.sv | 19 +
 rtl/packing_dispatch_pack_fifo.sv | 60 ++++++
 rtl/packing_dispatch.sv | 133 +++++++++++++
 tb/tb_packing_dispatch.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/packing_dispatch_pkg.sv
// Shared types and constants for the packing dispatcher: FSM states, default sizing, widths.
package packing_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    SEAL = 2'd2
  } state_t;

  localparam int DEF_DEPTH         = 4;
  localparam int DEF_PACKS_PER_BOX = 4;
  localparam int BOX_CNT_W         = 8;
  localparam int CODE_W            = 3;
  localparam int LEVEL_W           = 4;
  localparam int PACK_CNT_W        = 4;

  localparam logic [BOX_CNT_W-1:0] BOX_CNT_MAX = '1;

endpackage

// File: rtl/packing_dispatch_pack_fifo.sv
// Pack-code FIFO: storage, wrapping pointers and occupancy; head reads as zero when empty.
module pack_fifo
  import packing_dispatch_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [CODE_W-1:0]  wdata,
  output logic [CODE_W-1:0]  head,
  output logic [LEVEL_W-1:0] level,
  output logic               full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(DEPTH);

  logic [CODE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              empty;
  logic              wr_en;
  logic              rd_en;

  assign empty = (level == '0);
  assign full  = (level == LEVEL_FULL);
  assign rd_en = pop & ~empty;
  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign wr_en = push & (~full | rd_en);
  assign head  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/packing_dispatch.sv
// Packing dispatcher: CO edge detect, pack FIFO, send/seal FSM and box counter.
// Build option PACK_CODE_CHECK_EN rejects pack code 3'b000 and flags it on OVF.
module packing_dispatch
  import packing_dispatch_pkg::*;
#(
  parameter int DEPTH         = DEF_DEPTH,
  parameter int PACKS_PER_BOX = DEF_PACKS_PER_BOX
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 CO,
  input  logic [CODE_W-1:0]    PAC,
  input  logic                 PACK_RDY,
  output logic                 PACK_VLD,
  output logic [CODE_W-1:0]    PACK_CODE,
  output logic                 BOX_DONE,
  output logic [BOX_CNT_W-1:0] BOX_CNT,
  output logic [LEVEL_W-1:0]   LEVEL,
  output logic                 FULL,
  output logic                 OVF
);

  // state | meaning
  // IDLE  | FIFO empty, nothing offered
  // SEND  | head offered on PACK_CODE with PACK_VLD=1
  // SEAL  | one-cycle box seal, BOX_DONE=1, transfers blocked

  localparam logic [PACK_CNT_W-1:0] PACK_LAST = PACK_CNT_W'(PACKS_PER_BOX - 1);

  state_t                 state;
  logic                   co_q;
  logic                   co_edge;
  logic                   code_bad;
  logic                   push_req;
  logic                   push_acc;
  logic                   transfer;
  logic                   drop;
  logic [LEVEL_W-1:0]     level_next;
  logic [PACK_CNT_W-1:0]  pack_cnt;

  assign co_edge = CO & ~co_q;

`ifdef PACK_CODE_CHECK_EN
  assign code_bad = (PAC == '0);
`else
  assign code_bad = 1'b0;
`endif

  assign push_req   = co_edge & ~code_bad;
  assign transfer   = PACK_VLD & PACK_RDY;
  assign push_acc   = push_req & (~FULL | transfer);
  assign drop       = (push_req & FULL & ~transfer) | (co_edge & code_bad);
  // Occupancy after this edge; lets the FSM offer a pack the cycle after a push.
  assign level_next = LEVEL + LEVEL_W'(push_acc) - LEVEL_W'(transfer);

  pack_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_acc),
    .pop   (transfer),
    .wdata (PAC),
    .head  (PACK_CODE),
    .level (LEVEL),
    .full  (FULL)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      co_q <= 1'b0;
    end else begin
      co_q <= CO;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      PACK_VLD <= 1'b0;
      BOX_DONE <= 1'b0;
      pack_cnt <= '0;
      BOX_CNT  <= '0;
      OVF      <= 1'b0;
    end else begin
      BOX_DONE <= 1'b0;
      if (drop) begin
        OVF <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (level_next != '0) begin
            state    <= SEND;
            PACK_VLD <= 1'b1;
          end
        end
        SEND: begin
          if (transfer) begin
            if (pack_cnt == PACK_LAST) begin
              state    <= SEAL;
              PACK_VLD <= 1'b0;
              BOX_DONE <= 1'b1;
              pack_cnt <= '0;
              if (BOX_CNT != BOX_CNT_MAX) begin
                BOX_CNT <= BOX_CNT + 1'b1;
              end
            end else begin
              pack_cnt <= pack_cnt + 1'b1;
              if (level_next == '0) begin
                state    <= IDLE;
                PACK_VLD <= 1'b0;
              end
            end
          end
        end
        SEAL: begin
          if (level_next != '0) begin
            state    <= SEND;
            PACK_VLD <= 1'b1;
          end else begin
            state    <= IDLE;
            PACK_VLD <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          PACK_VLD <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packing_dispatch.sv
// Directed self-checking bench for packing_dispatch (default DEPTH=4, PACKS_PER_BOX=4).
module tb_packing_dispatch;

  logic       clk = 1'b0;
  logic       reset;
  logic       co;
  logic [2:0] pac;
  logic       pack_rdy;
  logic       pack_vld;
  logic [2:0] pack_code;
  logic       box_done;
  logic [7:0] box_cnt;
  logic [3:0] level;
  logic       full;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  packing_dispatch dut (
    .clk       (clk),
    .reset     (reset),
    .CO        (co),
    .PAC       (pac),
    .PACK_RDY  (pack_rdy),
    .PACK_VLD  (pack_vld),
    .PACK_CODE (pack_code),
    .BOX_DONE  (box_done),
    .BOX_CNT   (box_cnt),
    .LEVEL     (level),
    .FULL      (full),
    .OVF       (ovf)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; co = 1'b0; pac = 3'd0; pack_rdy = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic push(input logic [2:0] code);
    co = 1'b1; pac = code;
    cyc();
    co = 1'b0;
  endtask

  task automatic push_gap(input logic [2:0] code);
    push(code);
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1; co = 1'b0; pac = 3'd0; pack_rdy = 1'b0;
    cyc(); cyc();
    checks++; if (pack_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %0d exp 0", pack_vld); end
    checks++; if (pack_code !== 3'd0) begin errors++; $display("FAIL reset_code got %0d exp 0", pack_code); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (full !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL reset_flags got full=%0d ovf=%0d exp 0 0", full, ovf); end
    checks++; if (box_done !== 1'b0 || box_cnt !== 8'd0) begin errors++; $display("FAIL reset_box got done=%0d cnt=%0d exp 0 0", box_done, box_cnt); end
    reset = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    push(3'b011);
    checks++; if (pack_vld !== 1'b1 || pack_code !== 3'b011 || level !== 4'd1) begin errors++; $display("FAIL stall_first got vld=%0d code=%0d lvl=%0d exp 1 3 1", pack_vld, pack_code, level); end
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++; if (pack_vld !== 1'b1 || pack_code !== 3'b011 || level !== 4'd1) begin errors++; $display("FAIL stall_hold%0d got vld=%0d code=%0d lvl=%0d exp 1 3 1", i, pack_vld, pack_code, level); end
    end
  endtask

  task automatic test_box();
    do_reset();
    for (int i = 1; i <= 4; i++) push_gap(3'(i));
    checks++; if (level !== 4'd4 || full !== 1'b1) begin errors++; $display("FAIL box_fill got lvl=%0d full=%0d exp 4 1", level, full); end
    pack_rdy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (pack_vld !== 1'b1 || pack_code !== 3'(i)) begin errors++; $display("FAIL box_order%0d got vld=%0d code=%0d exp 1 %0d", i, pack_vld, pack_code, i); end
      cyc();
    end
    checks++; if (box_done !== 1'b1 || pack_vld !== 1'b0 || box_cnt !== 8'd1) begin errors++; $display("FAIL box_seal got done=%0d vld=%0d cnt=%0d exp 1 0 1", box_done, pack_vld, box_cnt); end
    pack_rdy = 1'b0;
    cyc();
    checks++; if (box_done !== 1'b0 || pack_vld !== 1'b0 || level !== 4'd0) begin errors++; $display("FAIL box_idle got done=%0d vld=%0d lvl=%0d exp 0 0 0", box_done, pack_vld, level); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 4; i++) push_gap(3'(i));
    checks++; if (full !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL ovf_full got full=%0d ovf=%0d exp 1 0", full, ovf); end
    push_gap(3'd5);
    checks++; if (ovf !== 1'b1 || level !== 4'd4) begin errors++; $display("FAIL ovf_drop got ovf=%0d lvl=%0d exp 1 4", ovf, level); end
    pack_rdy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (pack_code !== 3'(i)) begin errors++; $display("FAIL ovf_order%0d got %0d exp %0d", i, pack_code, i); end
      cyc();
    end
    cyc();
    checks++; if (level !== 4'd0 || pack_vld !== 1'b0 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_drain got lvl=%0d vld=%0d ovf=%0d exp 0 0 1", level, pack_vld, ovf); end
    pack_rdy = 1'b0;
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int i = 1; i <= 4; i++) push_gap(3'(i));
    pack_rdy = 1'b1; co = 1'b1; pac = 3'd6;
    cyc();
    co = 1'b0;
    checks++; if (level !== 4'd4 || ovf !== 1'b0 || full !== 1'b1 || pack_code !== 3'd2) begin errors++; $display("FAIL simul_accept got lvl=%0d ovf=%0d full=%0d code=%0d exp 4 0 1 2", level, ovf, full, pack_code); end
    for (int i = 2; i <= 4; i++) begin
      checks++; if (pack_code !== 3'(i)) begin errors++; $display("FAIL simul_order%0d got %0d exp %0d", i, pack_code, i); end
      cyc();
    end
    checks++; if (box_done !== 1'b1 || pack_vld !== 1'b0 || level !== 4'd1) begin errors++; $display("FAIL simul_seal got done=%0d vld=%0d lvl=%0d exp 1 0 1", box_done, pack_vld, level); end
    cyc();
    checks++; if (pack_vld !== 1'b1 || pack_code !== 3'd6) begin errors++; $display("FAIL simul_last got vld=%0d code=%0d exp 1 6", pack_vld, pack_code); end
    cyc();
    checks++; if (pack_vld !== 1'b0 || level !== 4'd0) begin errors++; $display("FAIL simul_empty got vld=%0d lvl=%0d exp 0 0", pack_vld, level); end
    pack_rdy = 1'b0;
  endtask

  task automatic test_co_held();
    do_reset();
    co = 1'b1; pac = 3'd5;
    repeat (10) cyc();
    co = 1'b0;
    cyc();
    checks++; if (level !== 4'd1 || pack_code !== 3'd5) begin errors++; $display("FAIL co_held got lvl=%0d code=%0d exp 1 5", level, pack_code); end
  endtask

  task automatic test_box_sat();
    do_reset();
    pack_rdy = 1'b1;
    for (int i = 0; i < 1020; i++) push_gap(3'd1);
    checks++; if (box_cnt !== 8'd255 || box_done !== 1'b1) begin errors++; $display("FAIL sat_255 got cnt=%0d done=%0d exp 255 1", box_cnt, box_done); end
    for (int i = 0; i < 4; i++) push_gap(3'd1);
    checks++; if (box_cnt !== 8'd255 || box_done !== 1'b1) begin errors++; $display("FAIL sat_hold got cnt=%0d done=%0d exp 255 1", box_cnt, box_done); end
    pack_rdy = 1'b0;
  endtask

  task automatic test_zero_code();
    do_reset();
    push(3'b000);
`ifdef PACK_CODE_CHECK_EN
    checks++; if (level !== 4'd0 || ovf !== 1'b1 || pack_vld !== 1'b0) begin errors++; $display("FAIL zero_reject got lvl=%0d ovf=%0d vld=%0d exp 0 1 0", level, ovf, pack_vld); end
`else
    checks++; if (level !== 4'd1 || pack_code !== 3'b000 || pack_vld !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL zero_accept got lvl=%0d code=%0d vld=%0d ovf=%0d exp 1 0 1 0", level, pack_code, pack_vld, ovf); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_gap(3'd1);
    push_gap(3'd2);
    pack_rdy = 1'b1;
    cyc();
    reset = 1'b1; co = 1'b1; pac = 3'd7;
    cyc();
    reset = 1'b0; co = 1'b0; pack_rdy = 1'b0;
    checks++; if (level !== 4'd0 || pack_vld !== 1'b0 || pack_code !== 3'd0) begin errors++; $display("FAIL rstmid_clear got lvl=%0d vld=%0d code=%0d exp 0 0 0", level, pack_vld, pack_code); end
    cyc();
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL rstmid_noedge got lvl=%0d exp 0", level); end
    for (int i = 1; i <= 4; i++) push_gap(3'(i));
    pack_rdy = 1'b1;
    repeat (3) cyc();
    checks++; if (box_done !== 1'b0 || pack_vld !== 1'b1) begin errors++; $display("FAIL rstmid_partial got done=%0d vld=%0d exp 0 1", box_done, pack_vld); end
    cyc();
    checks++; if (box_done !== 1'b1 || box_cnt !== 8'd1) begin errors++; $display("FAIL rstmid_seal got done=%0d cnt=%0d exp 1 1", box_done, box_cnt); end
    pack_rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_box();
    test_overflow();
    test_full_simul();
    test_co_held();
    test_box_sat();
    test_zero_code();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
